// File: rtl/countdown16.sv
// 16-bit loadable down counter used as the scroll-rate timer.
// Emits a one-cycle registered tc pulse per expiry; one-shot or periodic auto-reload.
module countdown16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  output logic [15:0] Q,
  output logic        tc,
  output logic        busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] q_r, q_s;
  logic [15:0] reload_r, reload_s;
  logic        tc_r, tc_s;
  logic        busy_r, busy_s;

  // Borrow chain: bit i toggles when all lower bits are zero (inverted carry taps).
  function automatic logic [15:0] borrow_dec(input logic [15:0] q);
    logic [15:0] b;
    b[0] = 1'b1;
    for (int i = 1; i < 16; i++) begin
      b[i] = b[i-1] & ~q[i-1];
    end
    return q ^ b;
  endfunction

  // Next-state logic: load > stop > start > counting.
  always_comb begin
    state_s  = state_r;
    q_s      = q_r;
    reload_s = reload_r;
    tc_s     = 1'b0;
    if (load) begin
      q_s      = load_val;
      reload_s = load_val;
      state_s  = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !stop && (q_r != 16'd0)) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_s = ST_IDLE;
          end else if (q_r > 16'd1) begin
            q_s = borrow_dec(q_r);
          end else if (q_r == 16'd1) begin
            tc_s = 1'b1;
            if (mode) begin
              q_s = reload_r;
            end else begin
              q_s     = 16'd0;
              state_s = ST_IDLE;
            end
          end else begin
            // Zero in RUN is unreachable; hold the count and park.
            state_s = ST_IDLE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
    busy_s = (state_s == ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      q_r      <= 16'd0;
      reload_r <= 16'd0;
      tc_r     <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      q_r      <= q_s;
      reload_r <= reload_s;
      tc_r     <= tc_s;
      busy_r   <= busy_s;
    end
  end

  assign Q    = q_r;
  assign tc   = tc_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_countdown16.sv
// Self-checking bench for countdown16: directed scenarios plus random stimulus
// compared every cycle against a behavioural timer model.
module tb_countdown16;

  logic        clk = 1'b0;
  logic        rst, load, start, stop, mode;
  logic [15:0] load_val;
  logic [15:0] q;
  logic        tc, busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: remaining count, reload period, running flag, expiry pulse.
  int unsigned m_q, m_reload;
  bit          m_run, m_tc;

  countdown16 dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .mode(mode),
    .Q(q), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_q = 0; m_reload = 0; m_run = 0; m_tc = 0;
    end else if (load) begin
      m_q = load_val; m_reload = load_val; m_run = 0; m_tc = 0;
    end else if (m_run && stop) begin
      m_run = 0; m_tc = 0;
    end else if (!m_run) begin
      m_tc = 0;
      if (start && !stop && m_q != 0) m_run = 1;
    end else if (m_q == 0) begin
      m_run = 0; m_tc = 0;
    end else begin
      m_q  = m_q - 1;
      m_tc = (m_q == 0);
      if (m_tc) begin
        if (mode) m_q = m_reload;
        else m_run = 0;
      end
    end
  endtask

  // One clock: model follows the sampled inputs, then outputs are compared.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("q", {16'd0, q}, m_q);
    check("tc", {31'd0, tc}, {31'd0, m_tc});
    check("busy", {31'd0, busy}, {31'd0, m_run});
  endtask

  task automatic idle_in();
    rst = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    idle_in(); load = 1'b1; load_val = v; step(); load = 1'b0;
  endtask

  task automatic do_start();
    idle_in(); start = 1'b1; step(); start = 1'b0;
  endtask

  initial begin
    m_q = 0; m_reload = 0; m_run = 0; m_tc = 0;
    idle_in(); mode = 1'b0; load_val = 16'd0;
    rst = 1'b1; step(); step(); rst = 1'b0;
    check("rst_q", {16'd0, q}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Reset mid-run at 0x1234, then start must be ignored.
    do_load(16'h1235); do_start(); step();
    check("pre_rst_q", {16'd0, q}, 32'h1234);
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_q", {16'd0, q}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_tc", {31'd0, tc}, 32'd0);
    do_start();
    check("zero_start_busy", {31'd0, busy}, 32'd0);

    // One-shot of 5.
    do_load(16'd5); do_start();
    check("os_busy_k", {31'd0, busy}, 32'd1);
    check("os_q_k", {16'd0, q}, 32'd5);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("os_q", {16'd0, q}, 5 - i);
      check("os_tc", {31'd0, tc}, (i == 5) ? 32'd1 : 32'd0);
      check("os_busy", {31'd0, busy}, (i < 5) ? 32'd1 : 32'd0);
    end
    step();
    check("os_tc_fall", {31'd0, tc}, 32'd0);

    // Periodic of 3 for 10 periods.
    mode = 1'b1; do_load(16'd3); do_start();
    for (int i = 1; i <= 30; i++) begin
      step();
      check("per_q", {16'd0, q}, (i % 3 == 0) ? 32'd3 : 3 - (i % 3));
      check("per_tc", {31'd0, tc}, (i % 3 == 0) ? 32'd1 : 32'd0);
    end
    mode = 1'b0;

    // Pause and resume.
    do_load(16'h0100); do_start();
    for (int i = 0; i < 16; i++) step();
    check("pause_pre", {16'd0, q}, 32'h00F0);
    stop = 1'b1; step(); stop = 1'b0;
    for (int i = 0; i < 19; i++) begin
      step();
      check("pause_hold", {16'd0, q}, 32'h00F0);
      check("pause_tc", {31'd0, tc}, 32'd0);
    end
    do_start();
    for (int i = 1; i <= 16'h00F0; i++) begin
      step();
      check("resume_tc", {31'd0, tc}, (i == 16'h00F0) ? 32'd1 : 32'd0);
    end
    do_load(16'd5);
    start = 1'b1; stop = 1'b1; step(); idle_in();
    check("startstop_busy", {31'd0, busy}, 32'd0);

    // Borrow chain boundaries.
    do_load(16'h8000); do_start(); step();
    check("borrow_8000", {16'd0, q}, 32'h7FFF);
    do_load(16'd1); do_start(); step();
    check("one_tc", {31'd0, tc}, 32'd1);
    check("one_q", {16'd0, q}, 32'd0);
    do_load(16'hFFFF); do_start();
    for (int i = 1; i <= 65535; i++) begin
      step();
      if (i == 65534) check("ffff_early", {31'd0, tc}, 32'd0);
    end
    check("ffff_tc", {31'd0, tc}, 32'd1);
    check("ffff_q", {16'd0, q}, 32'd0);

    // Load while running wins over start.
    do_load(16'd10); do_start(); step(); step(); step();
    check("mid_q7", {16'd0, q}, 32'd7);
    load = 1'b1; start = 1'b1; load_val = 16'd9; step(); idle_in();
    check("midload_q", {16'd0, q}, 32'd9);
    check("midload_busy", {31'd0, busy}, 32'd0);
    check("midload_tc", {31'd0, tc}, 32'd0);
    do_start(); step();
    check("midload_next", {16'd0, q}, 32'd8);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(199) == 0);
      load  = ($urandom_range(29) == 0);
      start = ($urandom_range(3) == 0);
      stop  = ($urandom_range(19) == 0);
      if ($urandom_range(24) == 0) mode = ~mode;
      load_val = ($urandom_range(9) == 0) ? 16'($urandom) : 16'($urandom_range(12));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
